// File: rtl/lbp_pkg.sv
// Shared constants for the LBP pixel datapath: window geometry and neighbour bit ordering.
package lbp_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WIN_SIZE   = 9;
  localparam int unsigned WIN_COLS   = 3;
  localparam int unsigned CENTER_IDX = 4;
  localparam int unsigned NUM_NBR    = WIN_SIZE - 1;

  // Window cell feeding each code bit, LSB first; the centre cell is skipped.
  localparam int unsigned NBR_IDX [NUM_NBR] = '{0, 1, 2, 3, 5, 6, 7, 8};

endpackage

// File: rtl/lbp_encode.sv
// Combinational LBP encoder: one bit per neighbour, set when the neighbour is >= the centre.
module lbp_encode
  import lbp_pkg::*;
#(
  parameter int unsigned DATA_W = lbp_pkg::DATA_W
) (
  input  logic [WIN_SIZE-1:0][DATA_W-1:0] win,
  output logic [NUM_NBR-1:0]              code
);

  always_comb begin
    code = '0;
    for (int b = 0; b < NUM_NBR; b++) begin
      code[b] = (win[NBR_IDX[b]] >= win[CENTER_IDX]);
    end
  end

endmodule

// File: rtl/lbp_datapath.sv
// LBP pixel datapath: 3x3 window register file with column shift, encoder and output register.
module lbp_datapath
  import lbp_pkg::*;
#(
  parameter int unsigned DATA_W = lbp_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   gray_data,
  input  logic [WIN_SIZE-1:0] En4Reg,
  input  logic                shift_win,
  input  logic                en4Out,
  output logic [DATA_W-1:0]   lbp_data,
  output logic [DATA_W-1:0]   win_center
);

  logic [WIN_SIZE-1:0][DATA_W-1:0] win_q, win_d;
  logic [NUM_NBR-1:0]              code;
  logic [DATA_W-1:0]               lbp_q;

  // Load beats shift; columns 0/1 take their right neighbour, column 2 holds unless loaded.
  always_comb begin
    win_d = win_q;
    for (int k = 0; k < WIN_SIZE; k++) begin
      if (En4Reg[k]) begin
        win_d[k] = gray_data;
      end else if (shift_win && ((k % WIN_COLS) != (WIN_COLS - 1))) begin
        win_d[k] = win_q[(k + 1) % WIN_SIZE];
      end
    end
  end

  lbp_encode #(
    .DATA_W (DATA_W)
  ) u_encode (
    .win  (win_q),
    .code (code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q <= '0;
      lbp_q <= '0;
    end else begin
      win_q <= win_d;
      if (en4Out) begin
        lbp_q <= DATA_W'(code);
      end
    end
  end

  assign lbp_data   = lbp_q;
  assign win_center = win_q[CENTER_IDX];

endmodule

// File: tb/tb_lbp_datapath.sv
// Scoreboard bench for lbp_datapath: directed cases then random traffic against a 3x3 model.
module tb_lbp_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gray_data;
  logic [8:0] En4Reg;
  logic       shift_win;
  logic       en4Out;
  logic [7:0] lbp_data;
  logic [7:0] win_center;

  lbp_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .gray_data  (gray_data),
    .En4Reg     (En4Reg),
    .shift_win  (shift_win),
    .en4Out     (en4Out),
    .lbp_data   (lbp_data),
    .win_center (win_center)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lbp;
    logic [7:0] center;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mwin [3][3];
  logic [7:0] model_lbp;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference LBP: walk the 3x3 grid row-major, skip the centre, one bit per neighbour.
  function automatic logic [7:0] ref_lbp();
    logic [7:0] r;
    int bitn;
    r = '0;
    bitn = 0;
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        if (!(row == 1 && col == 1)) begin
          r[bitn] = (mwin[row][col] >= mwin[1][1]);
          bitn++;
        end
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int row = 0; row < 3; row++)
      for (int col = 0; col < 3; col++) mwin[row][col] = 8'h00;
    model_lbp = 8'h00;
  endtask

  // One clock of stimulus; expectations for the following edge go to the scoreboard.
  task automatic step(input logic [8:0] en, input logic sh, input logic out, input logic [7:0] d);
    logic [7:0] nw [3][3];
    exp_t e;
    @(negedge clk);
    #1;
    En4Reg    = en;
    shift_win = sh;
    en4Out    = out;
    gray_data = d;
    if (out) model_lbp = ref_lbp();
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        if (en[row*3+col])      nw[row][col] = d;
        else if (sh && col < 2) nw[row][col] = mwin[row][col+1];
        else                    nw[row][col] = mwin[row][col];
      end
    end
    mwin     = nw;
    e.lbp    = model_lbp;
    e.center = mwin[1][1];
    exp_q.push_back(e);
  endtask

  task automatic load_cell(input int k, input logic [7:0] d);
    logic [8:0] en;
    en = 9'b0;
    en[k] = 1'b1;
    step(en, 1'b0, 1'b0, d);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    En4Reg    = 9'b0;
    shift_win = 1'b0;
    en4Out    = 1'b0;
    reset     = 1'b1;
    #1;
    check({tag, "_lbp_data"}, lbp_data, 8'h00);
    check({tag, "_win_center"}, win_center, 8'h00);
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  // Monitor: each negedge, the result of the edge just passed is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_lbp_data", lbp_data, e.lbp);
        check("sb_win_center", win_center, e.center);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    gray_data = 8'h00;
    En4Reg    = 9'b0;
    shift_win = 1'b0;
    en4Out    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    check("reset_lbp_data", lbp_data, 8'h00);
    check("reset_win_center", win_center, 8'h00);
    reset = 1'b0;

    // Empty window after reset: all cells equal -> every bit set.
    step(9'b0, 1'b0, 1'b1, 8'h00);

    // Full load 10..90, then encode.
    for (int k = 0; k < 9; k++) load_cell(k, 8'((k + 1) * 10));
    step(9'b0, 1'b0, 1'b1, 8'h00);
    step(9'b0, 1'b0, 1'b0, 8'h00);
    check("full_load_const", lbp_data, 8'hF0);

    // Shift + first fetch, then refill column 2 of rows 1/2.
    step(9'b000000100, 1'b1, 1'b0, 8'd99);
    load_cell(5, 8'd100);
    load_cell(8, 8'd100);
    step(9'b0, 1'b0, 1'b1, 8'h00);

    // Same-edge: output sees old g4, load of g4=0 still lands.
    step(9'b000010000, 1'b0, 1'b1, 8'h00);
    step(9'b0, 1'b0, 1'b1, 8'h00);
    step(9'b0, 1'b0, 1'b0, 8'h00);
    check("same_edge_const", lbp_data, 8'hFF);

    // Equality: all cells 7F via multi-hot load, then centre 80.
    step(9'h1FF, 1'b0, 1'b0, 8'h7F);
    step(9'b0, 1'b0, 1'b1, 8'h00);
    load_cell(4, 8'h80);
    step(9'b0, 1'b0, 1'b1, 8'h00);
    step(9'b0, 1'b0, 1'b0, 8'h00);
    check("eq_centre_above_const", lbp_data, 8'h00);

    // Hold: window churns, no en4Out.
    for (int i = 0; i < 20; i++)
      step(9'($urandom), 1'($urandom), 1'b0, 8'($urandom));

    // Reset mid-operation, then confirm the window really cleared.
    async_reset("midop");
    step(9'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic; bias some pixels towards the centre value to hit equality.
    for (int i = 0; i < 300; i++) begin
      logic [8:0] en;
      logic [7:0] d;
      en = ($urandom_range(0, 3) == 0) ? 9'($urandom) : (9'b1 << $urandom_range(0, 8));
      d  = ($urandom_range(0, 3) == 0) ? mwin[1][1] : 8'($urandom);
      step(en, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3), d);
    end

    async_reset("final");
    step(9'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
